// File: rtl/cic_interpolator.sv
// cic_interpolator
//   Five-stage CIC interpolator (differential delay 1) feeding the DAC path.
//   A low-rate signed sample is pulled from upstream once every
//   INTERPOLATION_RATIO clocks. The combs run at that low rate. Their output is
//   zero-stuffed up to the clk rate, and five integrators run on every clk. The
//   integrator output is shifted right by 'gain', saturated and registered.
//
// Ports
//   clk            system clock, output sample rate
//   rst_n          asynchronous active-low reset
//   gain           arithmetic right shift applied to the last integrator
//   data_in        signed low-rate input sample
//   data_in_valid  upstream has a sample
//   data_in_ready  sample is taken this cycle (phase count == R-1)
//   data_out       signed interpolated sample, new every clk
//   data_clk       registered low-rate clock for upstream, 50% duty
//   underrun       one-cycle pulse after a strobe that had no valid sample
//   overflow       one-cycle pulse when data_out was saturated
module cic_interpolator #(
  parameter int DATA_WIDTH          = 12,
  parameter int REGISTER_WIDTH      = 64,
  parameter int INTERPOLATION_RATIO = 16,
  parameter int GAIN_WIDTH          = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [GAIN_WIDTH-1:0]        gain,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_clk,
  output logic                         underrun,
  output logic                         overflow
);

  localparam int CW = $clog2(INTERPOLATION_RATIO);
  localparam int NS = 5;
  localparam logic [CW-1:0] LAST = CW'(INTERPOLATION_RATIO - 1);
  localparam logic signed [REGISTER_WIDTH-1:0] SAT_HI =
    REGISTER_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [REGISTER_WIDTH-1:0] SAT_LO = -SAT_HI - 1;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          strobe;

  logic signed [REGISTER_WIDTH-1:0] x;
  logic signed [REGISTER_WIDTH-1:0] x_d;
  logic signed [REGISTER_WIDTH-1:0] u;
  logic signed [REGISTER_WIDTH-1:0] shifted;
  logic signed [REGISTER_WIDTH-1:0] comb   [1:NS];
  logic signed [REGISTER_WIDTH-1:0] comb_d [1:NS-1];
  logic signed [REGISTER_WIDTH-1:0] integ  [1:NS];

  logic signed [DATA_WIDTH-1:0] out_next;
  logic                         ovf_next;

  always_comb begin
    count_next    = count + CW'(1);
    strobe        = (count == LAST);
    data_in_ready = strobe;

    // A missing sample on the strobe is fed in as zero.
    x = data_in_valid ? REGISTER_WIDTH'(data_in) : '0;

    // Zero-stuffing: the comb output enters the integrators only in the
    // cycle right after the strobe edge that produced it.
    u = (count == '0) ? comb[NS] : '0;

    // Shift amounts at or beyond the register width collapse to the sign.
    if (int'(gain) >= REGISTER_WIDTH) begin
      shifted = integ[NS][REGISTER_WIDTH-1] ? '1 : '0;
    end else begin
      shifted = integ[NS] >>> gain;
    end

    out_next = shifted[DATA_WIDTH-1:0];
    ovf_next = 1'b0;
    if (shifted > SAT_HI) begin
      out_next = SAT_HI[DATA_WIDTH-1:0];
      ovf_next = 1'b1;
    end else if (shifted < SAT_LO) begin
      out_next = SAT_LO[DATA_WIDTH-1:0];
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      x_d      <= '0;
      data_out <= '0;
      data_clk <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      for (int k = 1; k <= NS; k++) begin
        comb[k]  <= '0;
        integ[k] <= '0;
      end
      for (int k = 1; k <= NS - 1; k++) begin
        comb_d[k] <= '0;
      end
    end else begin
      count    <= count_next;
      // High for the first half of the period, so the rising edge lands on
      // count 0, one cycle after the strobe.
      data_clk <= ~count_next[CW-1];
      underrun <= strobe & ~data_in_valid;
      data_out <= out_next;
      overflow <= ovf_next;

      integ[1] <= integ[1] + u;
      for (int k = 2; k <= NS; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end

      // Pipelined comb chain: each stage differences the previous stage's
      // value from the prior strobe, so a sample needs one strobe per stage.
      if (strobe) begin
        x_d     <= x;
        comb[1] <= x - x_d;
        for (int k = 2; k <= NS; k++) begin
          comb[k]     <= comb[k-1] - comb_d[k-1];
          comb_d[k-1] <= comb[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Testbench for cic_interpolator: reference model plus directed scenarios.
module tb_cic_interpolator;

  localparam int DW = 12;
  localparam int RW = 64;
  localparam int R  = 16;
  localparam int GW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [GW-1:0]        gain;
  logic signed [DW-1:0] data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic signed [DW-1:0] data_out;
  logic                 data_clk;
  logic                 underrun;
  logic                 overflow;

  always #5 clk = ~clk;

  cic_interpolator #(
    .DATA_WIDTH(DW),
    .REGISTER_WIDTH(RW),
    .INTERPOLATION_RATIO(R),
    .GAIN_WIDTH(GW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gain(gain),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_out(data_out),
    .data_clk(data_clk),
    .underrun(underrun),
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  int edges;
  int accepted;

  typedef struct {
    logic signed [DW-1:0] dout;
    logic                 ovf;
    logic                 und;
    logic                 dclk;
  } exp_t;

  exp_t sb[$];

  // Reference model state (64-bit wrap matches REGISTER_WIDTH).
  longint m_xd;
  longint m_c  [1:5];
  longint m_cd [1:4];
  longint m_i  [1:5];
  int     m_cnt;

  logic signed [DW-1:0] obs_out;
  logic obs_ovf, obs_und, obs_rdy, obs_dclk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_xd  = 0;
    m_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      m_c[k] = 0;
      m_i[k] = 0;
    end
    for (int k = 1; k <= 4; k++) m_cd[k] = 0;
    sb.delete();
  endtask

  // Advance the model by one clk edge and queue the expected register outputs.
  task automatic model_step(input logic v, input logic signed [DW-1:0] d);
    longint x, u, s;
    logic signed [63:0] sv;
    exp_t e;
    bit strobe;
    strobe = (m_cnt == R - 1);
    x = v ? longint'(d) : 0;
    u = (m_cnt == 0) ? m_c[5] : 0;
    if (int'(gain) >= RW) s = (m_i[5] < 0) ? -1 : 0;
    else s = m_i[5] >>> gain;
    e.ovf = 1'b0;
    sv = s;
    if (s > 2047) begin
      sv = 2047;
      e.ovf = 1'b1;
    end else if (s < -2048) begin
      sv = -2048;
      e.ovf = 1'b1;
    end
    e.dout = sv[DW-1:0];
    for (int k = 5; k >= 2; k--) m_i[k] += m_i[k-1];
    m_i[1] += u;
    if (strobe) begin
      for (int k = 5; k >= 2; k--) begin
        m_c[k] = m_c[k-1] - m_cd[k-1];
        m_cd[k-1] = m_c[k-1];
      end
      m_c[1] = x - m_xd;
      m_xd = x;
    end
    e.und = strobe && !v;
    m_cnt = (m_cnt + 1) % R;
    e.dclk = (m_cnt < R / 2);
    sb.push_back(e);
  endtask

  // One clock: drive inputs, check ready, step the model, then compare.
  task automatic cyc(input logic v, input logic signed [DW-1:0] d);
    exp_t e;
    data_in_valid = v;
    data_in = d;
    obs_rdy = data_in_ready;
    chk("ready", data_in_ready, (m_cnt == R - 1));
    if (data_in_ready && v) accepted++;
    model_step(v, d);
    @(posedge clk);
    #1;
    edges++;
    e = sb.pop_front();
    obs_out  = data_out;
    obs_ovf  = overflow;
    obs_und  = underrun;
    obs_dclk = data_clk;
    chk("data_out", data_out, e.dout);
    chk("overflow", overflow, e.ovf);
    chk("underrun", underrun, e.und);
    chk("data_clk", data_clk, e.dclk);
  endtask

  // Called #1 after a rising edge: asserts reset mid-period.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_clk", data_clk, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", data_in_ready, 0);
    model_reset();
    data_in_valid = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out", data_out, 0);
    chk("rst_hold_clk", data_clk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    accepted = 0;
  endtask

  task automatic idle_check();
    for (int e = 0; e < 48; e++) begin
      cyc(1'b0, '0);
      chk("idle_ready", obs_rdy, (e % R == R - 1));
      chk("idle_underrun", obs_und, (edges % R == 0));
      chk("idle_data_clk", obs_dclk, ((edges % R) < R / 2));
      chk("idle_out", obs_out, 0);
    end
  endtask

  task automatic dc_run(input logic signed [DW-1:0] d, input int periods,
                        input int settle, input logic signed [DW-1:0] exp_out,
                        input logic exp_ovf, input string tag);
    int bad_out = 0;
    int bad_ovf = 0;
    int und_cnt = 0;
    for (int i = 0; i < periods * R; i++) begin
      cyc(1'b1, d);
      if (i >= settle * R) begin
        if (obs_out !== exp_out) bad_out++;
        if (obs_ovf !== exp_ovf) bad_ovf++;
      end
      if (obs_und) und_cnt++;
    end
    chk({tag, "_out_bad"}, bad_out, 0);
    chk({tag, "_ovf_bad"}, bad_ovf, 0);
    chk({tag, "_underruns"}, und_cnt, 0);
    chk({tag, "_last_out"}, obs_out, exp_out);
  endtask

  initial begin
    int first_nz, reach, mono_bad, over, und_cnt;
    bit drop_pending;
    logic v;
    logic signed [DW-1:0] prev, min_out;

    rst_n = 1'b1;
    gain = 8'd16;
    data_in = '0;
    data_in_valid = 1'b0;
    edges = 0;
    accepted = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    idle_check();

    // DC unity, continuous valid: one sample per R clocks.
    do_reset();
    gain = 8'd16;
    dc_run(12'sd100, 200, 12, 12'sd100, 1'b0, "dc100");
    chk("dc100_accepted", accepted, 200);

    dc_run(-12'sd2048, 20, 15, -12'sd2048, 1'b0, "neg_g16");
    gain = 8'd15;
    dc_run(-12'sd2048, 5, 1, -12'sd2048, 1'b1, "neg_g15");
    dc_run(12'sd2047, 20, 15, 12'sd2047, 1'b1, "pos_g15");

    // Shift beyond register width: sign only.
    gain = 8'd200;
    cyc(1'b1, 12'sd2047);
    cyc(1'b1, 12'sd2047);
    chk("gain_big_pos", obs_out, 0);
    gain = 8'd16;
    dc_run(-12'sd2048, 20, 15, -12'sd2048, 1'b0, "neg_g16b");
    gain = 8'd70;
    cyc(1'b1, -12'sd2048);
    cyc(1'b1, -12'sd2048);
    chk("gain_big_neg", obs_out, -1);

    // Step 0 -> 512. Settling is timed from the first nonzero output, which
    // already includes the pipelined comb latency.
    do_reset();
    gain = 8'd16;
    for (int i = 0; i < 10 * R; i++) cyc(1'b1, '0);
    first_nz = -1;
    reach = -1;
    mono_bad = 0;
    over = 0;
    prev = '0;
    for (int i = 0; i < 16 * R; i++) begin
      cyc(1'b1, 12'sd512);
      if (obs_out < prev) mono_bad++;
      if (obs_out > 12'sd512) over++;
      if (first_nz < 0 && obs_out != 0) first_nz = edges;
      if (reach < 0 && obs_out == 12'sd512) reach = edges;
      prev = obs_out;
    end
    chk("step_monotonic_bad", mono_bad, 0);
    chk("step_overshoot", over, 0);
    chk("step_reached", (reach >= 0), 1);
    chk("step_settle_time", ((reach - first_nz) <= 5 * R + 6), 1);
    chk("step_final", obs_out, 512);

    // One dropped strobe: single underrun, a dip, then recovery.
    drop_pending = 1'b1;
    und_cnt = 0;
    accepted = 0;
    min_out = 12'sd512;
    for (int i = 0; i < 20 * R; i++) begin
      v = !(drop_pending && m_cnt == R - 1 && i > 2 * R);
      if (!v) drop_pending = 1'b0;
      cyc(v, 12'sd512);
      if (obs_und) und_cnt++;
      if (obs_out < min_out) min_out = obs_out;
    end
    chk("drop_underruns", und_cnt, 1);
    chk("drop_accepted", accepted, 19);
    chk("drop_dip", (min_out < 12'sd512), 1);
    chk("drop_recovered", obs_out, 512);

    // Reset in the middle of a period while DC 100 is flowing.
    do_reset();
    gain = 8'd16;
    for (int i = 0; i < 20 * R + 7; i++) cyc(1'b1, 12'sd100);
    chk("pre_reset_out", obs_out, 100);
    chk("pre_reset_data_clk", obs_dclk, 1);
    do_reset();
    idle_check();
    dc_run(12'sd100, 200, 12, 12'sd100, 1'b0, "dc100_again");
    chk("dc100_again_accepted", accepted, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
